idli_pred_rf_m: RTL
===================

# idli_pred_rf_m

Parametrised predicate register file with scoreboarding for the idli core. It generalises the single-read/single-write predicate file to N predicates, multiple read and write ports, and combining writes (SET/AND/OR/XOR) for compound compares. Per-register pending bits let issue logic stall on predicates still being produced by in-flight compares. It sits between decode/issue (read, reserve) and the comparison/ALU writeback path (write).

## Interface
- NUM_PREGS, 4: predicate count including hardwired-true top register PT = NUM_PREGS-1; must be ≥2.
- NUM_RD, 2: read ports.
- NUM_WR, 1: write ports.
- PREG_W, $clog2(NUM_PREGS): derived predicate index width; not overridable.
- i_prf_gck  in  1  clock.
- i_prf_rst  in  1  reset; synchronous, active-high.
- i_prf_rd  in  NUM_RD×PREG_W  read index per port.
- o_prf_rd_data  out  NUM_RD  read value per port.
- o_prf_rd_pend  out  NUM_RD  register is reserved and not yet written.
- i_prf_rsv_en  in  1  reserve a predicate for an in-flight producer.
- i_prf_rsv  in  PREG_W  reserved index.
- i_prf_wr_en  in  NUM_WR  write enable per port.
- i_prf_wr  in  NUM_WR×PREG_W  write index per port.
- i_prf_wr_op  in  NUM_WR×2  0 SET, 1 AND, 2 OR, 3 XOR.
- i_prf_wr_data  in  NUM_WR  write operand.

## Operation
- State: value_q[NUM_PREGS-1], pend_q[NUM_PREGS-1]; PT has no flops, reads 1, pend 0.
- Write result: SET→data; AND/OR/XOR→value_q[r] op data, always using registered (pre-edge) value.
- Multiple write ports hitting the same register in one cycle: highest port index wins; lower ports discarded, not chained.
- Write clears pend for that register; reserve sets it.
- Reserve and write to same register in one cycle: value updated, pend stays 1 (reserve wins, newer producer).
- Writes and reserves to PT ignored; PT never pending.
- Out-of-range indices (≥NUM_PREGS when NUM_PREGS not a power of two): reads return 1/pend 0; writes and reserves ignored.
- Read: returns value_q/pend_q, or bypassed next-cycle value (see Configuration).
- Reset: all value_q = 0, all pend_q = 0; reset dominates same-cycle writes/reserves.

## Timing
- Reads combinational, zero latency.
- Writes/reserves take effect at next rising i_prf_gck; visible in flops next cycle.
- o_prf_rd_data reset value: 0 for P0..PT-1, 1 for PT; o_prf_rd_pend reset value: 0 (with bypass, subject to same-cycle write/reserve inputs, which reset then discards).
- No stall/handshake inside block; issue must hold while o_prf_rd_pend=1.
- Reserve issued cycle N is seen as pend on reads from cycle N+1 (never bypassed).

## Configuration
- IDLI_PRF_BYPASS_EN defined: read of register r being written this cycle returns the winning write's computed result and pend 0 (pend 1 only if pend_q already… no: pend = 0 unless reserved in a prior cycle and not written). Precisely: data = write result, pend = 0.
- Undefined: reads return value_q and pend_q only; write visible one cycle later. Reduces read-path depth; issue logic then adds one stall cycle.

## Test plan
- Reset, then read all ports of P0..P2 and PT -> data 0,0,0,1; pend all 0.
- Write P1 SET 1 cycle N, read P1 cycle N -> 1 with bypass, 0 without; cycle N+1 -> 1 either way.
- P2=1; write P2 AND 0 on port0 and OR 1 on port1 (NUM_WR=2) same cycle -> P2=1 (port1 wins, uses old value 1).
- Reserve P0 cycle N -> pend 1 from N+1; write P0 SET 1 plus reserve P0 cycle N+3 -> N+4 data 1, pend 1; write only cycle N+5 -> pend 0 at N+6.
- Write/reserve PT with data 0 -> PT reads 1, pend 0 throughout.
- Reserve P1 and write P1 SET 1 with i_prf_rst high -> next cycle P1 data 0, pend 0.

Source files
------------

// File: rtl/idli_pred_rf_m.sv
// idli_pred_rf_m -- predicate register file with per-register scoreboarding.
//
// This block holds NUM_PREGS predicates. The top register, PT = NUM_PREGS-1,
// is hardwired true. Decode/issue reads predicates and reserves them for
// in-flight compares. The compare/ALU writeback path writes them with
// SET/AND/OR/XOR combining ops. A pending bit per register lets issue stall
// until the producer has written.
//
// Optional feature: define IDLI_PRF_BYPASS_EN to forward the current
// cycle's write result (and clear pend) onto the read ports. When it is left
// undefined, reads see only the registered state.
//
// Ports:
//   i_prf_gck       clock
//   i_prf_rst       synchronous active-high reset (dominates writes/reserves)
//   i_prf_rd        NUM_RD x PREG_W read indices
//   o_prf_rd_data   per-port read value (PT and out-of-range indices read 1)
//   o_prf_rd_pend   per-port pending flag (reserved, not yet written)
//   i_prf_rsv_en    reserve request
//   i_prf_rsv       reserve index
//   i_prf_wr_en     per-port write enable
//   i_prf_wr        NUM_WR x PREG_W write indices
//   i_prf_wr_op     NUM_WR x 2 op: 0 SET, 1 AND, 2 OR, 3 XOR
//   i_prf_wr_data   per-port write operand

// One read port. The read vectors are padded to the full index space, with
// constant "true, not pending" entries above the flopped registers. Because
// of that padding, PT and out-of-range indices need no extra compare.
module idli_pred_rf_rd_lane #(
  parameter int NIDX   = 4,
  parameter int PREG_W = 2
) (
  input  logic [PREG_W-1:0] i_idx,
  input  logic [NIDX-1:0]   i_val,
  input  logic [NIDX-1:0]   i_pend,
  output logic              o_data,
  output logic              o_pend
);
  assign o_data = i_val[i_idx];
  assign o_pend = i_pend[i_idx];
endmodule

module idli_pred_rf_m #(
  parameter  int NUM_PREGS = 4,
  parameter  int NUM_RD    = 2,
  parameter  int NUM_WR    = 1,
  localparam int PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic                     i_prf_gck,
  input  logic                     i_prf_rst,
  input  logic [NUM_RD*PREG_W-1:0] i_prf_rd,
  output logic [NUM_RD-1:0]        o_prf_rd_data,
  output logic [NUM_RD-1:0]        o_prf_rd_pend,
  input  logic                     i_prf_rsv_en,
  input  logic [PREG_W-1:0]        i_prf_rsv,
  input  logic [NUM_WR-1:0]        i_prf_wr_en,
  input  logic [NUM_WR*PREG_W-1:0] i_prf_wr,
  input  logic [NUM_WR*2-1:0]      i_prf_wr_op,
  input  logic [NUM_WR-1:0]        i_prf_wr_data
);
  localparam int NREG = NUM_PREGS - 1;   // flopped registers P0..PT-1
  localparam int NIDX = 1 << PREG_W;     // full index space seen by reads

  logic [NREG-1:0] r_val, r_pend;
  logic [NREG-1:0] w_nxt_val, w_nxt_pend, w_wr_hit;
  logic [NIDX-1:0] w_rd_val, w_rd_pend;

  // Next state. Ports are scanned in ascending order, so the highest-index
  // port hitting a register overwrites the lower ones. Every port combines
  // with the registered value, so lower-port results are dropped rather than
  // chained. Indices of PT and above never match a flopped register, which
  // makes such writes and reserves no-ops.
  always_comb begin
    w_nxt_val  = r_val;
    w_nxt_pend = r_pend;
    w_wr_hit   = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (i_prf_wr_en[p] && (i_prf_wr[p*PREG_W +: PREG_W] == PREG_W'(r))) begin
          w_wr_hit[r] = 1'b1;
          case (i_prf_wr_op[p*2 +: 2])
            2'd0:    w_nxt_val[r] = i_prf_wr_data[p];
            2'd1:    w_nxt_val[r] = r_val[r] & i_prf_wr_data[p];
            2'd2:    w_nxt_val[r] = r_val[r] | i_prf_wr_data[p];
            default: w_nxt_val[r] = r_val[r] ^ i_prf_wr_data[p];
          endcase
        end
      end
      // A same-cycle reserve belongs to a newer producer, so it beats the write.
      if (i_prf_rsv_en && (i_prf_rsv == PREG_W'(r)))
        w_nxt_pend[r] = 1'b1;
      else if (w_wr_hit[r])
        w_nxt_pend[r] = 1'b0;
    end
  end

  always_ff @(posedge i_prf_gck) begin
    if (i_prf_rst) begin
      r_val  <= '0;
      r_pend <= '0;
    end else begin
      r_val  <= w_nxt_val;
      r_pend <= w_nxt_pend;
    end
  end

  // Read-visible state. Reserves are never forwarded; only writes are.
  always_comb begin
    w_rd_val  = '1;
    w_rd_pend = '0;
`ifdef IDLI_PRF_BYPASS_EN
    w_rd_val[NREG-1:0]  = w_nxt_val;
    w_rd_pend[NREG-1:0] = r_pend & ~w_wr_hit;
`else
    w_rd_val[NREG-1:0]  = r_val;
    w_rd_pend[NREG-1:0] = r_pend;
`endif
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    idli_pred_rf_rd_lane #(.NIDX(NIDX), .PREG_W(PREG_W)) u_lane (
      .i_idx  (i_prf_rd[i*PREG_W +: PREG_W]),
      .i_val  (w_rd_val),
      .i_pend (w_rd_pend),
      .o_data (o_prf_rd_data[i]),
      .o_pend (o_prf_rd_pend[i])
    );
  end
endmodule
